alu_74181_seq: RTL and testbench

- Parametrised, multi-cycle successor to the 4-bit 74181 arithmetic slice.
- Implements the full 74181 function set: arithmetic mode and logic mode (M input), on WIDTH-bit operands.
- Each cycle it processes SLICES_PER_CYCLE 4-bit slices, LSB first. Carry is rippled between cycles through an internal register.
- Sits behind the register/IO wrapper. Uses a valid/ready handshake and reports F, carry-out, A=B, zero and signed-overflow flags.

---
 rtl/alu_74181_pkg.sv | 30 +++
 rtl/alu_74181_seq_if.sv | 31 +++
 rtl/alu_74181_slice.sv | 69 ++++++
 rtl/alu_74181_seq.sv | 122 ++++++++++++
 tb/tb_alu_74181_seq.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_74181_pkg.sv
// Shared types and constants for the sequential 74181-style ALU.
// Select codes are named after the arithmetic-mode function they pick.
package alu_74181_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] S_A            = 4'b0000;
  localparam logic [3:0] S_A_OR_B       = 4'b0001;
  localparam logic [3:0] S_A_OR_NB      = 4'b0010;
  localparam logic [3:0] S_MINUS1       = 4'b0011;
  localparam logic [3:0] S_A_PLUS_ANB   = 4'b0100;
  localparam logic [3:0] S_AOB_PLUS_ANB = 4'b0101;
  localparam logic [3:0] S_SUB_M1       = 4'b0110;
  localparam logic [3:0] S_ANB_M1       = 4'b0111;
  localparam logic [3:0] S_A_PLUS_AB    = 4'b1000;
  localparam logic [3:0] S_ADD          = 4'b1001;
  localparam logic [3:0] S_AONB_PLUS_AB = 4'b1010;
  localparam logic [3:0] S_AB_M1        = 4'b1011;
  localparam logic [3:0] S_DOUBLE       = 4'b1100;
  localparam logic [3:0] S_AOB_PLUS_A   = 4'b1101;
  localparam logic [3:0] S_AONB_PLUS_A  = 4'b1110;
  localparam logic [3:0] S_A_M1         = 4'b1111;

endpackage

// File: rtl/alu_74181_seq_if.sv
// Request/result bus of the sequential ALU.
interface alu_74181_seq_if #(
    parameter int WIDTH = 16
);
    // Valid/ready: a transfer happens on a rising edge where valid and ready are
    // both 1; the producer holds its payload stable while valid=1 and ready=0.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       s;
    logic             m;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] f;
    logic             cout;
    logic             aeqb;
    logic             zero;
    logic             ovf;

    modport master (
        output in_valid, a, b, s, m, cin, out_ready,
        input  in_ready, out_valid, f, cout, aeqb, zero, ovf
    );

    modport slave (
        input  in_valid, a, b, s, m, cin, out_ready,
        output in_ready, out_valid, f, cout, aeqb, zero, ovf
    );
endinterface

// File: rtl/alu_74181_slice.sv
// Combinational 4-bit 74181 slice with active-high data and carry.
// c3 is the carry into bit 3, used by the sequencer for signed overflow.
module alu_74181_slice
    import alu_74181_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic [3:0]         s,
    input  logic               m,
    input  logic               cin,
    output logic [SLICE_W-1:0] f,
    output logic               cout,
    output logic               c3
);
    logic [3:0] x, y, lf;
    logic [4:0] sum;
    logic [3:0] low;

    always_comb begin
        x = 4'h0;
        y = 4'h0;
        unique case (s)
            S_A:            begin x = a;       y = 4'h0;    end
            S_A_OR_B:       begin x = a | b;   y = 4'h0;    end
            S_A_OR_NB:      begin x = a | ~b;  y = 4'h0;    end
            S_MINUS1:       begin x = 4'h0;    y = 4'hF;    end
            S_A_PLUS_ANB:   begin x = a;       y = a & ~b;  end
            S_AOB_PLUS_ANB: begin x = a | b;   y = a & ~b;  end
            S_SUB_M1:       begin x = a;       y = ~b;      end
            S_ANB_M1:       begin x = a & ~b;  y = 4'hF;    end
            S_A_PLUS_AB:    begin x = a;       y = a & b;   end
            S_ADD:          begin x = a;       y = b;       end
            S_AONB_PLUS_AB: begin x = a | ~b;  y = a & b;   end
            S_AB_M1:        begin x = a & b;   y = 4'hF;    end
            S_DOUBLE:       begin x = a;       y = a;       end
            S_AOB_PLUS_A:   begin x = a | b;   y = a;       end
            S_AONB_PLUS_A:  begin x = a | ~b;  y = a;       end
            default:        begin x = a;       y = 4'hF;    end
        endcase
    end

    always_comb begin
        lf = 4'h0;
        unique case (s)
            4'h0:    lf = ~a;
            4'h1:    lf = ~(a | b);
            4'h2:    lf = ~a & b;
            4'h3:    lf = 4'h0;
            4'h4:    lf = ~(a & b);
            4'h5:    lf = ~b;
            4'h6:    lf = a ^ b;
            4'h7:    lf = a & ~b;
            4'h8:    lf = ~a | b;
            4'h9:    lf = ~(a ^ b);
            4'hA:    lf = b;
            4'hB:    lf = a & b;
            4'hC:    lf = 4'hF;
            4'hD:    lf = a | ~b;
            4'hE:    lf = a | b;
            default: lf = a;
        endcase
    end

    assign sum  = {1'b0, x} + {1'b0, y} + {4'b0, cin};
    assign low  = {1'b0, x[2:0]} + {1'b0, y[2:0]} + {3'b0, cin};
    assign f    = m ? lf : sum[3:0];
    assign cout = ~m & sum[4];
    assign c3   = ~m & low[3];
endmodule

// File: rtl/alu_74181_seq.sv
// Multi-cycle ALU: SLICES_PER_CYCLE chained 74181 slices per step, LSB first,
// with the inter-step carry held in carry_q.
module alu_74181_seq
    import alu_74181_pkg::*;
#(
    parameter int WIDTH            = 16,
    parameter int SLICES_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    alu_74181_seq_if.slave  bus,
    output state_t          dbg_state
);
    localparam int STEP_W = SLICE_W * SLICES_PER_CYCLE;
    localparam int N      = WIDTH / STEP_W;
    localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;

    state_t           state;
    logic [CNT_W-1:0] step;
    logic             carry_q;
    logic [WIDTH-1:0] a_q, b_q, f_q;
    logic [3:0]       s_q;
    logic             m_q;
    logic             out_valid_q, cout_q, aeqb_q, zero_q, ovf_q;

    logic [STEP_W-1:0] a_step, b_step, f_step;
    logic [WIDTH-1:0]  f_next;
    logic              cin_v  [SLICES_PER_CYCLE];
    logic              cout_v [SLICES_PER_CYCLE];
    logic              c3_v   [SLICES_PER_CYCLE];
    logic              last_step;

    assign a_step    = a_q[int'(step) * STEP_W +: STEP_W];
    assign b_step    = b_q[int'(step) * STEP_W +: STEP_W];
    assign last_step = (step == CNT_W'(N - 1));

    for (genvar g = 0; g < SLICES_PER_CYCLE; g++) begin : g_slice
        if (g == 0) begin : g_first
            assign cin_v[g] = carry_q;
        end else begin : g_next
            assign cin_v[g] = cout_v[g-1];
        end
        alu_74181_slice u_slice (
            .a    (a_step[g*SLICE_W +: SLICE_W]),
            .b    (b_step[g*SLICE_W +: SLICE_W]),
            .s    (s_q),
            .m    (m_q),
            .cin  (cin_v[g]),
            .f    (f_step[g*SLICE_W +: SLICE_W]),
            .cout (cout_v[g]),
            .c3   (c3_v[g])
        );
    end

    // Flags at the last step must see the bits being written on that same edge.
    always_comb begin
        f_next = f_q;
        f_next[int'(step) * STEP_W +: STEP_W] = f_step;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            step        <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= 4'h0;
            m_q         <= 1'b0;
            f_q         <= '0;
            out_valid_q <= 1'b0;
            cout_q      <= 1'b0;
            aeqb_q      <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        s_q     <= bus.s;
                        m_q     <= bus.m;
                        carry_q <= bus.cin;
                        step    <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    f_q     <= f_next;
                    carry_q <= cout_v[SLICES_PER_CYCLE-1];
                    step    <= step + 1'b1;
                    if (last_step) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        cout_q      <= cout_v[SLICES_PER_CYCLE-1];
                        ovf_q       <= ~m_q & (c3_v[SLICES_PER_CYCLE-1] ^
                                               cout_v[SLICES_PER_CYCLE-1]);
                        aeqb_q      <= &f_next;
                        zero_q      <= ~|f_next;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.f         = f_q;
    assign bus.cout      = cout_q;
    assign bus.aeqb      = aeqb_q;
    assign bus.zero      = zero_q;
    assign bus.ovf       = ovf_q;
    assign dbg_state     = state;
endmodule

// File: tb/tb_alu_74181_seq.sv
// Randomized and directed bench for alu_74181_seq against a full-width
// arithmetic reference model; also covers 32-bit widths with 1, 2 and 8 slices.
module tb_alu_74181_seq;
  import alu_74181_pkg::*;

  typedef struct {
    logic [31:0] f;
    logic        cout;
    logic        ovf;
  } res_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_74181_seq_if #(.WIDTH(16)) bus ();
  alu_74181_seq_if #(.WIDTH(32)) bus_w1 ();
  alu_74181_seq_if #(.WIDTH(32)) bus_w2 ();
  alu_74181_seq_if #(.WIDTH(32)) bus_w8 ();
  state_t dbg, dbg_w1, dbg_w2, dbg_w8;

  alu_74181_seq #(.WIDTH(16), .SLICES_PER_CYCLE(1)) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg));
  alu_74181_seq #(.WIDTH(32), .SLICES_PER_CYCLE(1)) u_w1 (
    .clk(clk), .rst(rst), .bus(bus_w1), .dbg_state(dbg_w1));
  alu_74181_seq #(.WIDTH(32), .SLICES_PER_CYCLE(2)) u_w2 (
    .clk(clk), .rst(rst), .bus(bus_w2), .dbg_state(dbg_w2));
  alu_74181_seq #(.WIDTH(32), .SLICES_PER_CYCLE(8)) u_w8 (
    .clk(clk), .rst(rst), .bus(bus_w8), .dbg_state(dbg_w8));

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_miss = 0;
  logic [19:0] exp_q[$];  // {cout, aeqb, zero, ovf, f[15:0]}

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: F = X + Y + cin over w bits, or the bitwise logic function.
  function automatic res_t ref_model(input logic [31:0] a, input logic [31:0] b,
                                     input logic [3:0] s, input logic m, input logic cin,
                                     input int w);
    logic [63:0] mask, aa, bb, na, nb, x, y, sum;
    res_t r;
    mask = (64'd1 << w) - 64'd1;
    aa = {32'd0, a} & mask;
    bb = {32'd0, b} & mask;
    na = ~aa & mask;
    nb = ~bb & mask;
    x = 64'd0;
    y = 64'd0;
    sum = 64'd0;
    r.cout = 1'b0;
    r.ovf  = 1'b0;
    if (m) begin
      case (s)
        4'h0: sum = na;
        4'h1: sum = ~(aa | bb);
        4'h2: sum = na & bb;
        4'h3: sum = 64'd0;
        4'h4: sum = ~(aa & bb);
        4'h5: sum = nb;
        4'h6: sum = aa ^ bb;
        4'h7: sum = aa & nb;
        4'h8: sum = na | bb;
        4'h9: sum = ~(aa ^ bb);
        4'hA: sum = bb;
        4'hB: sum = aa & bb;
        4'hC: sum = mask;
        4'hD: sum = aa | nb;
        4'hE: sum = aa | bb;
        default: sum = aa;
      endcase
      r.f = 32'(sum & mask);
    end else begin
      case (s)
        4'h0: begin x = aa;       y = 64'd0;    end
        4'h1: begin x = aa | bb;  y = 64'd0;    end
        4'h2: begin x = aa | nb;  y = 64'd0;    end
        4'h3: begin x = 64'd0;    y = mask;     end
        4'h4: begin x = aa;       y = aa & nb;  end
        4'h5: begin x = aa | bb;  y = aa & nb;  end
        4'h6: begin x = aa;       y = nb;       end
        4'h7: begin x = aa & nb;  y = mask;     end
        4'h8: begin x = aa;       y = aa & bb;  end
        4'h9: begin x = aa;       y = bb;       end
        4'hA: begin x = aa | nb;  y = aa & bb;  end
        4'hB: begin x = aa & bb;  y = mask;     end
        4'hC: begin x = aa;       y = aa;       end
        4'hD: begin x = aa | bb;  y = aa;       end
        4'hE: begin x = aa | nb;  y = aa;       end
        default: begin x = aa;    y = mask;     end
      endcase
      sum    = x + y + {63'd0, cin};
      r.f    = 32'(sum & mask);
      r.cout = sum[w];
      r.ovf  = (x[w-1] == y[w-1]) && (sum[w-1] != x[w-1]);
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                        input logic m, input logic cin, input int hold);
    res_t r;
    logic [15:0] fe;
    logic [19:0] exp;
    int lat;
    r  = ref_model({16'd0, a}, {16'd0, b}, s, m, cin, 16);
    fe = r.f[15:0];
    exp_q.push_back({r.cout, &fe, ~|fe, r.ovf, fe});
    @(negedge clk);
    check("in_ready_idle", bus.in_ready, 1);
    bus.in_valid = 1'b1; bus.a = a; bus.b = b; bus.s = s; bus.m = m; bus.cin = cin;
    @(negedge clk);
    // Keep a garbage request pending; it must be neither latched nor accepted.
    bus.a = 16'($urandom); bus.b = 16'($urandom); bus.s = 4'($urandom); bus.cin = ~cin;
    check("in_ready_run", bus.in_ready, 0);
    check("state_run", dbg, RUN);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 4);
    check("in_ready_done", bus.in_ready, 0);
    exp = exp_q.pop_front();
    check("f", bus.f, exp[15:0]);
    check("cout", bus.cout, exp[19]);
    check("aeqb", bus.aeqb, exp[18]);
    check("zero", bus.zero, exp[17]);
    check("ovf", bus.ovf, exp[16]);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", bus.out_valid, 1);
      check("hold_result", {bus.cout, bus.aeqb, bus.zero, bus.ovf, bus.f}, exp);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("released_valid", bus.out_valid, 0);
    check("released_ready", bus.in_ready, 1);
    check("kept_result", {bus.cout, bus.aeqb, bus.zero, bus.ovf, bus.f}, exp);
  endtask

  task automatic run_wide(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s,
                          input logic m, input logic cin);
    res_t r;
    int lat1, lat2, lat8;
    r = ref_model(a, b, s, m, cin, 32);
    @(negedge clk);
    bus_w1.a = a; bus_w1.b = b; bus_w1.s = s; bus_w1.m = m; bus_w1.cin = cin;
    bus_w2.a = a; bus_w2.b = b; bus_w2.s = s; bus_w2.m = m; bus_w2.cin = cin;
    bus_w8.a = a; bus_w8.b = b; bus_w8.s = s; bus_w8.m = m; bus_w8.cin = cin;
    bus_w1.in_valid = 1'b1; bus_w2.in_valid = 1'b1; bus_w8.in_valid = 1'b1;
    @(negedge clk);
    bus_w1.in_valid = 1'b0; bus_w2.in_valid = 1'b0; bus_w8.in_valid = 1'b0;
    lat1 = -1; lat2 = -1; lat8 = -1;
    for (int c = 0; c < 12; c++) begin
      if (lat1 < 0 && bus_w1.out_valid) lat1 = c;
      if (lat2 < 0 && bus_w2.out_valid) lat2 = c;
      if (lat8 < 0 && bus_w8.out_valid) lat8 = c;
      @(negedge clk);
    end
    check("w32s1_latency", lat1, 8);
    check("w32s2_latency", lat2, 4);
    check("w32s8_latency", lat8, 1);
    check("w32s1_f", bus_w1.f, r.f);
    check("w32s2_f", bus_w2.f, r.f);
    check("w32s8_f", bus_w8.f, r.f);
    check("w32s1_cout", bus_w1.cout, r.cout);
    check("w32s2_cout", bus_w2.cout, r.cout);
    check("w32s8_cout", bus_w8.cout, r.cout);
    check("w32s1_zero", bus_w1.zero, r.f == 32'd0);
    check("w32s8_ovf", bus_w8.ovf, r.ovf);
    bus_w1.out_ready = 1'b1; bus_w2.out_ready = 1'b1; bus_w8.out_ready = 1'b1;
    @(negedge clk);
    bus_w1.out_ready = 1'b0; bus_w2.out_ready = 1'b0; bus_w8.out_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.s = '0; bus.m = 1'b0; bus.cin = 1'b0;
    bus_w1.in_valid = 1'b0; bus_w1.out_ready = 1'b0;
    bus_w1.a = '0; bus_w1.b = '0; bus_w1.s = '0; bus_w1.m = 1'b0; bus_w1.cin = 1'b0;
    bus_w2.in_valid = 1'b0; bus_w2.out_ready = 1'b0;
    bus_w2.a = '0; bus_w2.b = '0; bus_w2.s = '0; bus_w2.m = 1'b0; bus_w2.cin = 1'b0;
    bus_w8.in_valid = 1'b0; bus_w8.out_ready = 1'b0;
    bus_w8.a = '0; bus_w8.b = '0; bus_w8.s = '0; bus_w8.m = 1'b0; bus_w8.cin = 1'b0;
    #12;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", {bus.cout, bus.aeqb, bus.zero, bus.ovf, bus.f}, 20'd0);
    check("rst_state", dbg, IDLE);
    @(negedge clk);
    rst = 1'b0;

    run_op(16'h1234, 16'h0FFF, S_ADD,    1'b0, 1'b0, 0);
    run_op(16'h1234, 16'h0FFF, S_SUB_M1, 1'b0, 1'b1, 0);
    run_op(16'h5A5A, 16'h5A5A, S_SUB_M1, 1'b0, 1'b0, 0);
    run_op(16'h7FFF, 16'h0001, S_ADD,    1'b0, 1'b0, 5);
    run_op(16'($urandom), 16'($urandom), S_MINUS1, 1'b0, 1'b0, 0);
    run_op(16'($urandom), 16'($urandom), S_MINUS1, 1'b0, 1'b1, 0);
    run_op(16'hF0F0, 16'hFF00, 4'b0110,  1'b1, 1'b1, 0);

    for (int sel = 0; sel < 16; sel++) begin
      for (int md = 0; md < 2; md++) begin
        run_op(16'($urandom), 16'($urandom), 4'(sel), 1'(md), 1'($urandom_range(0, 1)),
               $urandom_range(0, 2));
      end
    end

    // Asynchronous reset two steps into an operation.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.a = 16'h0F0F; bus.b = 16'h0101; bus.s = S_ADD; bus.m = 1'b0;
    bus.cin = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_f", bus.f, 16'h0000);
    check("midrst_state", dbg, IDLE);
    #1;
    rst = 1'b0;
    run_op(16'hABCD, 16'h1111, S_ADD, 1'b0, 1'b1, 0);

    run_wide(32'hFFFF_FFFF, 32'h0000_0001, S_ADD, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      run_wide($urandom, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
    end

    if (exp_q.size() != 0) check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
